// File: rtl/assert_range_monitor.sv
// assert_range_monitor
// Runtime range-assertion checker. Each of NUM_CH channels is checked every
// cycle. A sample that falls inside the forbidden range [FORBID_LO, FORBID_HI]
// is a violation. Each violation is stamped with a free-running cycle counter
// and held in a one-deep pending slot for its channel. An arbiter moves the
// lowest-index occupied slot into a first-word-fall-through record FIFO. The
// FIFO drains over a valid/ready report port.
//
// Optional build macro: ASSERT_RANGE_MONITOR_HALT_EN.
// When it is defined, the first violation sets a sticky halt. Halt freezes the
// cycle counter and stops all further detection. When it is undefined, halt
// is tied to 0.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                global check enable
//   ch_valid[NUM_CH]      per-channel sample qualifier
//   ch_value              channel i at bits [i*VAL_W +: VAL_W]
//   rpt_valid/rpt_ready   failure record handshake
//   rpt_ch/value/cycle    failure record contents (zero while rpt_valid = 0)
//   fail_count            violations detected, saturating
//   drop_count            violations lost to a busy pending slot, saturating
//   any_fail              sticky, at least one violation since reset
//   halt                  sticky stop flag (optional feature)
//
// Handshake: a record transfers on every rising edge where rpt_valid and
// rpt_ready are both 1. While rpt_valid is 1 and rpt_ready is 0, the rpt_*
// fields stay stable. rpt_valid never depends on rpt_ready.
module assert_range_monitor #(
  parameter int          NUM_CH     = 4,
  parameter int          VAL_W      = 8,
  parameter int unsigned FORBID_LO  = 1,
  parameter int unsigned FORBID_HI  = 2,
  parameter int          CYC_W      = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CNT_W      = 16,
  localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH*VAL_W-1:0] ch_value,
  output logic                    rpt_valid,
  input  logic                    rpt_ready,
  output logic [CH_W-1:0]         rpt_ch,
  output logic [VAL_W-1:0]        rpt_value,
  output logic [CYC_W-1:0]        rpt_cycle,
  output logic [CNT_W-1:0]        fail_count,
  output logic [CNT_W-1:0]        drop_count,
  output logic                    any_fail,
  output logic                    halt
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  // The extra bits absorb up to 16 simultaneous increments before saturation.
  localparam int SUM_W = CNT_W + 5;
  localparam logic [VAL_W-1:0] LO = VAL_W'(FORBID_LO);
  localparam logic [VAL_W-1:0] HI = VAL_W'(FORBID_HI);

  logic [CYC_W-1:0]  cyc;
  logic              halt_q;
  logic [NUM_CH-1:0] viol;
  logic [NUM_CH-1:0] drain;
  logic [NUM_CH-1:0] drop;
  logic [NUM_CH-1:0] pend_vld;
  logic [VAL_W-1:0]  pend_val [NUM_CH];
  logic [CYC_W-1:0]  pend_cyc [NUM_CH];
  logic [CH_W-1:0]   sel;
  logic              sel_any;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [CH_W-1:0]   mem_ch  [FIFO_DEPTH];
  logic [VAL_W-1:0]  mem_val [FIFO_DEPTH];
  logic [CYC_W-1:0]  mem_cyc [FIFO_DEPTH];
  logic [4:0]        fail_inc;
  logic [4:0]        drop_inc;
  logic [SUM_W-1:0]  fail_sum;
  logic [SUM_W-1:0]  drop_sum;

`ifdef ASSERT_RANGE_MONITOR_HALT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     halt_q <= 1'b0;
    else if (|viol) halt_q <= 1'b1;
  end
`else
  assign halt_q = 1'b0;
`endif
  assign halt = halt_q;

  // Detection. The bounds are unsigned and have the same width as the sample.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [VAL_W-1:0] v;
    assign v       = ch_value[g*VAL_W +: VAL_W];
    assign viol[g] = enable & ch_valid[g] & ~halt_q & (v >= LO) & (v <= HI);
  end

  // Fixed-priority arbiter. The scan runs downward so the lowest index wins.
  always_comb begin
    sel     = '0;
    sel_any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_vld[i]) begin
        sel     = CH_W'(i);
        sel_any = 1'b1;
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = ~empty & rpt_ready;
  // A full FIFO still accepts a push when it pops on the same edge.
  assign push  = sel_any & (~full | pop);
  assign drain = push ? (NUM_CH'(1) << sel) : '0;
  // A slot that empties this edge may reload on the same edge, so no drop.
  assign drop  = viol & pend_vld & ~drain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_val[i] <= '0;
        pend_cyc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (viol[i] && (!pend_vld[i] || drain[i])) begin
          pend_vld[i] <= 1'b1;
          pend_val[i] <= ch_value[i*VAL_W +: VAL_W];
          pend_cyc[i] <= cyc;
        end else if (drain[i]) begin
          pend_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ch[wr_ptr[AW-1:0]]  <= sel;
      mem_val[wr_ptr[AW-1:0]] <= pend_val[sel];
      mem_cyc[wr_ptr[AW-1:0]] <= pend_cyc[sel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FWFT head. It is forced to zero when empty so reset and idle read as zero.
  assign rpt_valid = ~empty;
  assign rpt_ch    = empty ? '0 : mem_ch[rd_ptr[AW-1:0]];
  assign rpt_value = empty ? '0 : mem_val[rd_ptr[AW-1:0]];
  assign rpt_cycle = empty ? '0 : mem_cyc[rd_ptr[AW-1:0]];

  always_comb begin
    fail_inc = '0;
    drop_inc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fail_inc = fail_inc + 5'(viol[i]);
      drop_inc = drop_inc + 5'(drop[i]);
    end
  end

  assign fail_sum = SUM_W'(fail_count) + SUM_W'(fail_inc);
  assign drop_sum = SUM_W'(drop_count) + SUM_W'(drop_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc        <= '0;
      fail_count <= '0;
      drop_count <= '0;
      any_fail   <= 1'b0;
    end else begin
      if (!halt_q) cyc <= cyc + CYC_W'(1);
      fail_count <= (|fail_sum[SUM_W-1:CNT_W]) ? '1 : fail_sum[CNT_W-1:0];
      drop_count <= (|drop_sum[SUM_W-1:CNT_W]) ? '1 : drop_sum[CNT_W-1:0];
      if (|viol) any_fail <= 1'b1;
    end
  end

endmodule

// File: tb/tb_assert_range_monitor.sv
// Bench for assert_range_monitor (default parameters).
// Sections: clock/reset, driver tasks, scoreboard with a queue-based model,
// vector table, directed sequences, randomized runs, final report.
module tb_assert_range_monitor;

  localparam int NUM_CH     = 4;
  localparam int VAL_W      = 8;
  localparam int CYC_W      = 64;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 16;
  localparam int CH_W       = 2;
  localparam int LO         = 1;
  localparam int HI         = 2;
  localparam int REC_W      = CH_W + VAL_W + CYC_W;
`ifdef ASSERT_RANGE_MONITOR_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam longint MAXC = (longint'(1) << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic                    clk;
  logic                    rst_n;
  logic                    enable;
  logic [NUM_CH-1:0]       ch_valid;
  logic [NUM_CH*VAL_W-1:0] ch_value;
  logic                    rpt_valid;
  logic                    rpt_ready;
  logic [CH_W-1:0]         rpt_ch;
  logic [VAL_W-1:0]        rpt_value;
  logic [CYC_W-1:0]        rpt_cycle;
  logic [CNT_W-1:0]        fail_count;
  logic [CNT_W-1:0]        drop_count;
  logic                    any_fail;
  logic                    halt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assert_range_monitor #(
    .NUM_CH(NUM_CH), .VAL_W(VAL_W), .FORBID_LO(LO), .FORBID_HI(HI),
    .CYC_W(CYC_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_valid(ch_valid),
    .ch_value(ch_value), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_ch(rpt_ch), .rpt_value(rpt_value), .rpt_cycle(rpt_cycle),
    .fail_count(fail_count), .drop_count(drop_count),
    .any_fail(any_fail), .halt(halt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // The model follows the rules directly. Pending slots are modelled as a flag
  // plus a record per channel. The FIFO is the expected queue. The counters
  // are plain integers clamped at the maximum.
  logic [REC_W-1:0] exp_q[$];
  bit   [NUM_CH-1:0] slot_has;
  logic [REC_W-1:0] slot_rec [NUM_CH];
  longint           fail_m;
  longint           drop_m;
  bit               any_m;
  bit               halt_m;
  logic [CYC_W-1:0] cyc_m;

  task automatic model_reset();
    exp_q.delete();
    slot_has = '0;
    fail_m   = 0;
    drop_m   = 0;
    any_m    = 1'b0;
    halt_m   = 1'b0;
    cyc_m    = '0;
  endtask

  task automatic model_check();
    logic [REC_W-1:0] r;
    chk("rpt_valid", 64'(rpt_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      r = exp_q[0];
      chk("rpt_ch",    64'(rpt_ch),    64'(r[REC_W-1 -: CH_W]));
      chk("rpt_value", 64'(rpt_value), 64'(r[CYC_W +: VAL_W]));
      chk("rpt_cycle", rpt_cycle,      r[CYC_W-1:0]);
    end
    chk("fail_count", 64'(fail_count), 64'(fail_m));
    chk("drop_count", 64'(drop_count), 64'(drop_m));
    chk("any_fail",   64'(any_fail),   64'(any_m));
    chk("halt",       64'(halt),       64'(halt_m));
  endtask

  task automatic model_step(input logic en, input logic [NUM_CH-1:0] vld,
                            input logic [NUM_CH*VAL_W-1:0] vals, input logic rdy);
    int         drained;
    bit         popping;
    int         nv;
    int         v;
    drained = -1;
    popping = rdy && (exp_q.size() > 0);
    if (exp_q.size() < FIFO_DEPTH || popping) begin
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (slot_has[i]) drained = i;
    end
    if (popping) void'(exp_q.pop_front());
    if (drained >= 0) begin
      exp_q.push_back(slot_rec[drained]);
      slot_has[drained] = 1'b0;
    end
    nv = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      v = int'(vals[i*VAL_W +: VAL_W]);
      if (en && vld[i] && !halt_m && v >= LO && v <= HI) begin
        nv++;
        if (fail_m < MAXC) fail_m++;
        if (slot_has[i]) begin
          if (drop_m < MAXC) drop_m++;
        end else begin
          slot_has[i] = 1'b1;
          slot_rec[i] = {CH_W'(i), VAL_W'(v), cyc_m};
        end
      end
    end
    if (nv > 0) any_m = 1'b1;
    if (!halt_m) cyc_m = cyc_m + 1;
    if (HALT_EN && nv > 0) halt_m = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge. It checks the current outputs and applies this
  // cycle's inputs, then moves to the next falling edge.
  task automatic cyc_step(input logic en, input logic [NUM_CH-1:0] vld,
                          input logic [NUM_CH*VAL_W-1:0] vals, input logic rdy);
    model_check();
    enable    = en;
    ch_valid  = vld;
    ch_value  = vals;
    rpt_ready = rdy;
    model_step(en, vld, vals, rdy);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cyc_step(1'b1, '0, '0, rdy);
  endtask

  function automatic logic [NUM_CH*VAL_W-1:0] put(input int ch, input logic [VAL_W-1:0] v);
    logic [NUM_CH*VAL_W-1:0] r;
    r = '0;
    r[ch*VAL_W +: VAL_W] = v;
    return r;
  endfunction

  // Leaves the bench at a falling edge in cycle 0.
  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    ch_valid  = '0;
    ch_value  = '0;
    rpt_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_rpt_valid", 64'(rpt_valid), 64'd0);
    chk("reset_rpt_cycle", rpt_cycle, 64'd0);
    chk("reset_rpt_value", 64'(rpt_value), 64'd0);
    chk("reset_fail", 64'(fail_count), 64'd0);
    chk("reset_drop", 64'(drop_count), 64'd0);
    chk("reset_any", 64'(any_fail), 64'd0);
    model_reset();
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             en;
    logic             vld;
    int               ch;
    logic [VAL_W-1:0] val;
    logic             exp_hit;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [VAL_W-1:0] v;
    logic [NUM_CH-1:0] mask;

    tbl[0] = '{1'b1, 1'b1, 0, 8'd0,   1'b0};
    tbl[1] = '{1'b1, 1'b1, 0, 8'd1,   1'b1};
    tbl[2] = '{1'b1, 1'b1, 1, 8'd2,   1'b1};
    tbl[3] = '{1'b1, 1'b1, 2, 8'd3,   1'b0};
    tbl[4] = '{1'b1, 1'b1, 3, 8'd255, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 0, 8'd1,   1'b0};
    tbl[6] = '{1'b1, 1'b0, 1, 8'd2,   1'b0};
    tbl[7] = '{1'b1, 1'b1, 3, 8'd1,   1'b1};
    tbl[8] = '{1'b1, 1'b1, 2, 8'd254, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 2, 8'd2,   1'b1};

    rst_n = 1'b0;

    // Table: one sample in cycle 0. The record is visible in cycle 2.
    for (int t = 0; t < 10; t++) begin
      do_reset();
      mask = tbl[t].vld ? (NUM_CH'(1) << tbl[t].ch) : '0;
      cyc_step(tbl[t].en, mask, put(tbl[t].ch, tbl[t].val), 1'b0);
      idle(1'b0);
      chk("tbl_fail", 64'(fail_count), 64'(tbl[t].exp_hit));
      chk("tbl_valid", 64'(rpt_valid), 64'(tbl[t].exp_hit));
      if (tbl[t].exp_hit) begin
        chk("tbl_ch", 64'(rpt_ch), 64'(tbl[t].ch));
        chk("tbl_value", 64'(rpt_value), 64'(tbl[t].val));
        chk("tbl_cycle", rpt_cycle, 64'd0);
      end
    end

    // Legal values only: nothing reported.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      v = (k % 3 == 0) ? 8'd0 : ((k % 3 == 1) ? 8'd3 : 8'd255);
      cyc_step(1'b1, 4'b0001, put(0, v), 1'b1);
    end
    chk("legal_valid", 64'(rpt_valid), 64'd0);
    chk("legal_fail", 64'(fail_count), 64'd0);
    chk("legal_any", 64'(any_fail), 64'd0);

    // A violation in cycle 5 is reported in cycle 7.
    do_reset();
    for (int k = 0; k < 5; k++) idle(1'b1);
    cyc_step(1'b1, 4'b0001, put(0, 8'd1), 1'b1);
    idle(1'b1);
    chk("lat_valid", 64'(rpt_valid), 64'd1);
    chk("lat_ch", 64'(rpt_ch), 64'd0);
    chk("lat_value", 64'(rpt_value), 64'd1);
    chk("lat_cycle", rpt_cycle, 64'd5);
    chk("lat_fail", 64'(fail_count), 64'd1);
    chk("lat_any", 64'(any_fail), 64'd1);

`ifndef ASSERT_RANGE_MONITOR_HALT_EN
    // All four channels in cycle 10 are reported in channel order.
    do_reset();
    for (int k = 0; k < 10; k++) idle(1'b1);
    cyc_step(1'b1, 4'hF, {4{8'd2}}, 1'b1);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (rpt_valid) begin
        chk("order_ch", 64'(rpt_ch), 64'(n));
        chk("order_value", 64'(rpt_value), 64'd2);
        chk("order_cycle", rpt_cycle, 64'd10);
        n++;
      end
      idle(1'b1);
    end
    chk("order_count", 64'(n), 64'd4);
    chk("order_fail", 64'(fail_count), 64'd4);
    chk("order_drop", 64'(drop_count), 64'd0);

    // Fill the FIFO with the consumer stalled, then drain it.
    do_reset();
    for (int k = 0; k < 20; k++) cyc_step(1'b1, 4'b0010, put(1, 8'd2), 1'b0);
    chk("fill_fail", 64'(fail_count), 64'd20);
    chk("fill_drop", 64'(drop_count), 64'd11);
    chk("fill_valid", 64'(rpt_valid), 64'd1);
    n = 0;
    for (int k = 0; k < 16; k++) begin
      if (rpt_valid) begin
        chk("drain_cycle", rpt_cycle, 64'(n));
        chk("drain_ch", 64'(rpt_ch), 64'd1);
        n++;
      end
      idle(1'b1);
    end
    chk("drain_count", 64'(n), 64'd9);
`else
    // Halt: the first violation, in cycle 3, freezes the monitor.
    do_reset();
    for (int k = 0; k < 3; k++) idle(1'b0);
    cyc_step(1'b1, 4'b0001, put(0, 8'd2), 1'b0);
    chk("halt_set", 64'(halt), 64'd1);
    for (int k = 4; k < 8; k++) idle(1'b0);
    cyc_step(1'b1, 4'b0010, put(1, 8'd1), 1'b0);
    idle(1'b0);
    chk("halt_fail", 64'(fail_count), 64'd1);
    chk("halt_cycle", rpt_cycle, 64'd3);
    chk("halt_valid", 64'(rpt_valid), 64'd1);
`endif

    // Stall with the record held, then assert reset mid-stall.
    do_reset();
    cyc_step(1'b1, 4'b0100, put(2, 8'd1), 1'b0);
    idle(1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 64'(rpt_valid), 64'd1);
      chk("stall_ch", 64'(rpt_ch), 64'd2);
      chk("stall_value", 64'(rpt_value), 64'd1);
      chk("stall_cycle", rpt_cycle, 64'd0);
      idle(1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(rpt_valid), 64'd0);
    chk("async_fail", 64'(fail_count), 64'd0);
    chk("async_drop", 64'(drop_count), 64'd0);
    chk("async_any", 64'(any_fail), 64'd0);
    chk("async_cycle", rpt_cycle, 64'd0);

    // Randomized runs, with the consumer's readiness rising from run to run.
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int k = 0; k < 400; k++) begin
        logic [NUM_CH*VAL_W-1:0] vals;
        for (int c = 0; c < NUM_CH; c++)
          vals[c*VAL_W +: VAL_W] = ($urandom_range(0, 3) == 0) ?
                                   VAL_W'($urandom_range(0, 255)) :
                                   VAL_W'($urandom_range(0, 4));
        cyc_step(($urandom_range(0, 9) != 0), NUM_CH'($urandom),
                 vals, ($urandom_range(0, 3) < r));
      end
      model_check();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/assert_range_monitor.md
Name: assert_range_monitor

Overview:
- Synthesizable, emulation-friendly runtime assertion checker.
- Watches NUM_CH independent sampled values and flags any sample inside a forbidden inclusive range [FORBID_LO, FORBID_HI].
- Timestamps each violation with a free-running cycle counter, buffers failure records in a FIFO, and drains them over a valid/ready report port to the display/logging buffer.
- Successor to single-signal, single-value assertion sites: generalised in channel count, value width, forbidden range and buffering.

Parameters:
- NUM_CH, 4, number of monitored channels (1..16)
- VAL_W, 8, width of each monitored value
- FORBID_LO, 1, lower bound of forbidden range, inclusive, unsigned
- FORBID_HI, 2, upper bound of forbidden range, inclusive, unsigned; FORBID_HI >= FORBID_LO
- CYC_W, 64, cycle counter / timestamp width
- FIFO_DEPTH, 8, failure record FIFO depth (power of 2, >= 2)
- CNT_W, 16, width of fail_count and drop_count

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  global check enable
- ch_valid  in  NUM_CH  per-channel sample qualifier
- ch_value  in  NUM_CH*VAL_W  channel i at bits [i*VAL_W +: VAL_W]
- rpt_valid  out  1  failure record available
- rpt_ready  in  1  consumer accepts record
- rpt_ch  out  $clog2(NUM_CH) (min 1)  failing channel index
- rpt_value  out  VAL_W  offending value
- rpt_cycle  out  CYC_W  cycle number of violation
- fail_count  out  CNT_W  total violations detected, saturating
- drop_count  out  CNT_W  violations lost, saturating
- any_fail  out  1  sticky: at least one violation since reset
- halt  out  1  see Optional Feature

Behaviour:
- Reset (async assert, sync release): cycle counter, all counters, pending flags, FIFO pointers, any_fail and halt = 0. rpt_valid = 0; rpt_ch, rpt_value and rpt_cycle = 0.
- Cycle counter:
  - Increments by 1 every clk after reset and wraps modulo 2^CYC_W.
  - The first cycle after reset release is cycle 0.
- Violation, channel i, cycle c: enable & ch_valid[i] & FORBID_LO <= value <= FORBID_HI, compared unsigned at VAL_W.
- Capture stage: one pending slot per channel.
  - Violation with slot empty: slot loads {value, c} at the clock edge.
  - Violation with slot occupied and not draining that cycle: new record discarded; drop_count += 1.
  - fail_count += 1 on every violation, captured or dropped.
  - Each counter takes at most one increment per channel per cycle; sum all simultaneous increments in one cycle, saturating at all-ones.
- Arbiter:
  - Each cycle, the lowest-index occupied slot writes to the FIFO if the FIFO is not full.
  - The slot frees on the same edge and may reload on that same edge (capture wins; no drop).
- FIFO and report port:
  - First-word-fall-through. rpt_* are valid when rpt_valid = 1.
  - A pop occurs when rpt_valid & rpt_ready.
  - Push and pop in the same cycle when full are both allowed; occupancy is unchanged.
  - rpt_* must hold stable while rpt_valid & !rpt_ready.
- Latency: violation at cycle c gives rpt_valid at the earliest in cycle c+2 (one edge to capture, one to push).
- any_fail: set on the first violation and cleared only by reset.
- enable = 0: no new violations are detected. Pending slots and FIFO continue draining. The cycle counter keeps running.
- Reset mid-drain: all records are lost and rpt_valid drops asynchronously.

Optional Feature:
- Macro: ASSERT_RANGE_MONITOR_HALT_EN.
- Defined:
  - halt goes to 1 on the edge following the first violation and stays sticky until reset.
  - While halt = 1, the cycle counter freezes and further violations are neither detected nor counted.
  - Already-captured records still drain.
- Undefined: halt is tied to 0 and the monitor runs indefinitely.

Test Plan:
- Reset, enable = 1, channel 0 values 0, 3, 255 for 10 cycles → rpt_valid = 0, fail_count = 0, any_fail = 0.
- At cycle 5, ch_value[0] = 1 with ch_valid[0] = 1, rpt_ready = 1 → record {ch 0, value 1, cycle 5} valid at cycle 7; fail_count = 1; any_fail = 1.
- At cycle 10, channels 0..3 all = 2 → four records with cycle 10 emerge in channel order 0, 1, 2, 3; fail_count = 4; drop_count = 0.
- rpt_ready = 0, channel 1 = 2 every cycle for 20 cycles → FIFO fills with 8 records (cycles n..n+7). The next violation lands in the pending slot; later ones increment drop_count. After 20 violations: fail_count = 20, drop_count = 11, FIFO holds 8 records plus 1 pending.
- Stall with rpt_valid = 1 and rpt_ready = 0 for 5 cycles → rpt_* unchanged. Assert rst_n = 0 mid-stall → rpt_valid = 0 immediately and all counters = 0.
- With ASSERT_RANGE_MONITOR_HALT_EN defined, violation at cycle 3 → halt = 1 from cycle 4, rpt_cycle = 3. A later violation at cycle 8 → fail_count stays 1.
